mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Multi-cycle multiply/divide unit owning the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO. Sits in the EX stage beside the combinational ALU. Receives the same forwarded `src1`/`src2` operands and asserts `busy` to stall the pipeline while an operation is in flight. MFHI/MFLO read `hi`/`lo` directly once `busy` is low.

## Interface
Parameters:
- `MUL_LAT`, default 3: number of busy cycles for MULT/MULTU. Legal range 1..8.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  issue request; sampled on the rising edge.
- `md_op`  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
- `src1`  in  32  rs operand (dividend / multiplicand / MTHI, MTLO source).
- `src2`  in  32  rt operand (divisor / multiplier).
- `busy`  out  1  registered; high while a MUL or DIV is in flight.
- `hi`  out  32  architectural HI register.
- `lo`  out  32  architectural LO register.

## Operation
- **States:** IDLE, MUL, DIV.
- **Accept:** a request is accepted only when `start && !busy`.
  - `start` while `busy` is ignored. The pipeline guarantees this does not occur; the bench asserts it.
  - Reserved `md_op` codes are accepted as no-ops: no state change.
- **MTHI / MTLO:** `hi <= src1` (MTHI) or `lo <= src1` (MTLO) on the accepting edge. State stays IDLE; `busy` stays low.
- **MULT / MULTU:**
  - On accept, latch both operands extended to 33 bits: sign-extended for MULT, zero-extended for MULTU.
  - Load a countdown with `MUL_LAT`, enter MUL.
  - When the count expires: `{hi,lo} <= product[63:0]`, return to IDLE.
- **DIV / DIVU:** radix-2 restoring divider on 32-bit magnitudes.
  - On accept, latch |src1|, |src2| (signed) or the raw values (unsigned), plus the operand signs. Counter = 32, enter DIV.
  - One quotient bit per cycle for 32 cycles, then one fix-up cycle. The fix-up applies signs and writes `lo <= quotient`, `hi <= remainder`, then returns to IDLE.
  - Signed rules: quotient truncates toward zero; the remainder takes the dividend's sign.
  - `0x80000000 / 0xFFFFFFFF` (DIV): `lo = 0x80000000`, `hi = 0`.
  - Divide by zero, both DIV and DIVU: `lo = 0xFFFFFFFF`, `hi = src1`. Full latency still applies.
- **Retention:** `hi`/`lo` hold their previous values throughout MUL/DIV and are updated only on the completing edge.
- **Reset:** any state goes to IDLE. `busy = 0`, `hi = 0`, `lo = 0`, counters and operand latches = 0. An in-flight operation is discarded.

## Timing
- Let edge 0 be the edge where `start` is accepted.
- **MUL:**
  - `busy` is 1 in cycles 1..`MUL_LAT`.
  - New `hi`/`lo` are visible, with `busy = 0`, from cycle `MUL_LAT + 1`.
- **DIV:**
  - `busy` is 1 in cycles 1..33 (32 iterations + fix-up).
  - Results are visible from cycle 34.
- **MTHI/MTLO:** the new value is visible in cycle 1.
- **Back-to-back:** a new `start` may be accepted in the first cycle `busy` is low. This is the same edge that is already showing the previous result.
- **Stall duty of the consumer:** `busy` is registered, so an MFHI/MFLO issued the cycle after MULT/DIV sees `busy = 1` and must stall. An MFHI/MFLO in the same cycle as the `start` reads the old HI/LO, which is the correct program order.
- **Reset priority:** `reset` overrides `start` on the same edge.

## Structure
- **Shared package `mdu_pkg`:**
  - `md_op_t` enum carrying the encodings above.
  - `mdu_state_t` enum (IDLE/MUL/DIV).
  - Constant `DIV_ITERS = 32`.
- **Sub-module `div_radix2`:** the iterative divider core, with ports `clk`, `reset`, `go`, `dividend`, `divisor`, `quot`, `rem`, `done`. Its interface covers magnitudes only. Sign handling and divide-by-zero override stay in `mul_div_unit`.
- **Multiply:** done inline as a 33×33 signed multiply into a registered product. The countdown only models latency.

## Test plan
- Reset, then MTHI `0x12345678`, then MTLO `0x9ABCDEF0` -> `hi = 0x12345678`, `lo = 0x9ABCDEF0`, each visible one cycle after its `start`; `busy` never rises.
- MULT `0xFFFFFFFE` × `0x00000003` -> `busy` high for exactly 3 cycles, then `hi = 0xFFFFFFFF`, `lo = 0xFFFFFFFA`. MULTU with the same operands -> `hi = 0x00000002`, `lo = 0xFFFFFFFA`.
- DIV `-7 / 2` -> `busy` high for 33 cycles, then `lo = 0xFFFFFFFD`, `hi = 0xFFFFFFFF`. DIVU `7 / 2` -> `lo = 3`, `hi = 1`.
- DIV `0x80000000 / 0xFFFFFFFF` -> `lo = 0x80000000`, `hi = 0`. DIVU `5 / 0` -> `lo = 0xFFFFFFFF`, `hi = 5` after the full 33 busy cycles.
- `reset` asserted in busy cycle 10 of a DIV -> the next cycle shows `busy = 0`, `hi = lo = 0`. A following MULTU `2 × 3` yields `lo = 6`, `hi = 0`.
- DIV in flight with `start` pulsed (MULT) mid-operation -> ignored, DIV result intact. A MULT issued on the first non-busy cycle completes normally; `hi`/`lo` stay stable during its busy window.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and constants for the multiply/divide unit
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } mdu_state_t;

  localparam int DIV_ITERS = 32;

endpackage

// File: rtl/div_radix2.sv
// rtl/div_radix2.sv - iterative radix-2 restoring divider on 32-bit magnitudes
module div_radix2
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        done
);

  logic [31:0] dvsr;
  logic [5:0]  cnt;
  logic [32:0] shifted;
  logic [32:0] trial;

  // quot doubles as the dividend shift register: dividend bits leave the top
  // while quotient bits enter at the bottom.
  assign shifted = {rem, quot[31]};
  assign trial   = shifted - {1'b0, dvsr};

  always_ff @(posedge clk) begin
    if (reset) begin
      quot <= '0;
      rem  <= '0;
      dvsr <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (go) begin
      quot <= dividend;
      rem  <= '0;
      dvsr <= divisor;
      cnt  <= 6'(DIV_ITERS);
      done <= 1'b0;
    end else if (cnt != 6'd0) begin
      if (!trial[32]) begin
        rem  <= trial[31:0];
        quot <= {quot[30:0], 1'b1};
      end else begin
        rem  <= shifted[31:0];
        quot <= {quot[30:0], 1'b0};
      end
      cnt  <= cnt - 6'd1;
      done <= (cnt == 6'd1);
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle MULT/DIV unit owning the HI/LO registers
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_t  state, state_n;
  logic [3:0]  mul_cnt;
  logic [32:0] mul_a, mul_b;
  logic [63:0] pa, pb, prod;
  logic        q_neg, r_neg, dz;
  logic [31:0] dvd_raw;
  logic        accept, mul_signed, div_signed, div_go;
  logic [31:0] dvd_mag, dvs_mag;
  logic [31:0] div_quot, div_rem;
  logic        div_done;

  assign accept     = start && !busy;
  assign mul_signed = (md_op == OP_MULT);
  assign div_signed = (md_op == OP_DIV);
  assign div_go     = accept && (state == IDLE) && (md_op == OP_DIV || md_op == OP_DIVU);
  assign dvd_mag    = (div_signed && src1[31]) ? -src1 : src1;
  assign dvs_mag    = (div_signed && src2[31]) ? -src2 : src2;

  // 33-bit operands extended to 64 bits; the low 64 bits of the product are exact.
  assign pa   = {{31{mul_a[32]}}, mul_a};
  assign pb   = {{31{mul_b[32]}}, mul_b};
  assign prod = pa * pb;

  div_radix2 u_div (
    .clk      (clk),
    .reset    (reset),
    .go       (div_go),
    .dividend (dvd_mag),
    .divisor  (dvs_mag),
    .quot     (div_quot),
    .rem      (div_rem),
    .done     (div_done)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (md_op)
            OP_MULT, OP_MULTU: state_n = MUL;
            OP_DIV, OP_DIVU:   state_n = DIV;
            default:           state_n = IDLE;
          endcase
        end
      end
      MUL:     if (mul_cnt == 4'd1) state_n = IDLE;
      DIV:     if (div_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      mul_cnt <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      dz      <= 1'b0;
      dvd_raw <= '0;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            case (md_op)
              OP_MULT, OP_MULTU: begin
                mul_a   <= {mul_signed & src1[31], src1};
                mul_b   <= {mul_signed & src2[31], src2};
                mul_cnt <= 4'(MUL_LAT);
              end
              OP_DIV, OP_DIVU: begin
                q_neg   <= div_signed & (src1[31] ^ src2[31]);
                r_neg   <= div_signed & src1[31];
                dz      <= (src2 == 32'd0);
                dvd_raw <= src1;
              end
              OP_MTHI: hi <= src1;
              OP_MTLO: lo <= src1;
              default: ;
            endcase
          end
        end
        MUL: begin
          mul_cnt <= mul_cnt - 4'd1;
          if (mul_cnt == 4'd1) begin
            hi <= prod[63:32];
            lo <= prod[31:0];
          end
        end
        DIV: begin
          // Fix-up cycle: apply signs, or the divide-by-zero override.
          if (div_done) begin
            if (dz) begin
              lo <= 32'hFFFF_FFFF;
              hi <= dvd_raw;
            end else begin
              lo <= q_neg ? -div_quot : div_quot;
              hi <= r_neg ? -div_rem : div_rem;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench with a cycle-level behavioural model
module tb_mul_div_unit;

  localparam int MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  mul_div_unit #(.MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .src1  (src1),
    .src2  (src2),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Model: architectural HI/LO plus a count of remaining busy cycles.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_cnt = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_cnt = 0;
    end else if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (start) begin
      case (md_op)
        3'd0: begin
          longint sp;
          sp = longint'($signed(src1)) * longint'($signed(src2));
          {p_hi, p_lo} = sp;
          m_cnt = MUL_LAT;
        end
        3'd1: begin
          logic [63:0] up;
          up = {32'd0, src1} * {32'd0, src2};
          {p_hi, p_lo} = up;
          m_cnt = MUL_LAT;
        end
        3'd2: begin
          int a, b;
          a = src1; b = src2;
          if (b == 0) begin p_lo = 32'hFFFF_FFFF; p_hi = src1; end
          else if (a == 32'h8000_0000 && b == -1) begin p_lo = 32'h8000_0000; p_hi = 0; end
          else begin p_lo = a / b; p_hi = a % b; end
          m_cnt = 33;
        end
        3'd3: begin
          if (src2 == 0) begin p_lo = 32'hFFFF_FFFF; p_hi = src1; end
          else begin p_lo = src1 / src2; p_hi = src1 % src2; end
          m_cnt = 33;
        end
        3'd4: m_hi = src1;
        3'd5: m_lo = src1;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (busy !== (m_cnt != 0) || hi !== m_hi || lo !== m_lo) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t busy=%b hi=%h lo=%h required busy=%b hi=%h lo=%h",
                 $time, busy, hi, lo, (m_cnt != 0), m_hi, m_lo);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; src1 = a; src2 = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL wait_idle timeout busy still=%b required=0", busy);
    end
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n, pre;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    issue(3'd4, 32'h1234_5678, 32'd0);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    issue(3'd5, 32'h9ABC_DEF0, 32'd0);
    check("mtlo_lo", lo, 32'h9ABC_DEF0);
    check("mtlo_busy", {31'd0, busy}, 32'd0);

    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    check("mult_lat", n, 32'd3);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    check("multu_hi", hi, 32'h0000_0002);
    check("multu_lo", lo, 32'hFFFF_FFFA);

    issue(3'd2, -32'sd7, 32'd2);
    wait_idle(n);
    check("div_lat", n, 32'd33);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    issue(3'd3, 32'd7, 32'd2);
    wait_idle(n);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'd0);
    issue(3'd3, 32'd5, 32'd0);
    wait_idle(n);
    check("divz_lat", n, 32'd33);
    check("divz_lo", lo, 32'hFFFF_FFFF);
    check("divz_hi", hi, 32'd5);

    issue(3'd2, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    issue(3'd1, 32'd2, 32'd3);
    wait_idle(n);
    check("post_rst_lo", lo, 32'd6);
    check("post_rst_hi", hi, 32'd0);

    issue(3'd3, 32'd100, 32'd7);
    pre = 1;
    repeat (4) begin @(negedge clk); pre++; end
    start = 1'b1; md_op = 3'd0; src1 = 32'd9; src2 = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_idle(n);
    check("ignored_lat", pre + n, 32'd33);
    check("ignored_lo", lo, 32'd14);
    check("ignored_hi", hi, 32'd2);
    issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    check("b2b_lo", lo, 32'd1);
    check("b2b_hi", hi, 32'd0);

    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), rand_operand(), rand_operand());
      if (busy === 1'b1 && $urandom_range(0, 3) == 0) begin
        start = 1'b1; md_op = 3'($urandom_range(0, 7)); src1 = $urandom; src2 = $urandom;
        @(negedge clk);
        start = 1'b0;
      end
      wait_idle(n);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
